// File: rtl/thermal_tuner_array.sv
// thermal_tuner_array
// Multi-channel ring-heater tuner. Each channel slews a heater code toward a
// target written through a valid/ready port, and turns the current code into
// a first-order sigma-delta heater enable stream.
// Optional build macro: THERMAL_TUNER_STAGGER_EN -- when defined, each
// channel's accumulator restarts at an evenly spaced phase offset so that
// equal-code channels do not pulse together.

module thermal_tuner_array #(
    parameter int NUM_CH     = 4,
    parameter int BIT_WIDTH  = 8,
    parameter int INIT_CODE  = 0,
    parameter int RAMP_STEP  = 1,
    parameter int UPDATE_DIV = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cfg_valid,
    output logic                          cfg_ready,
    input  logic [CH_W-1:0]               cfg_ch,
    input  logic [BIT_WIDTH-1:0]          cfg_code,
    output logic [NUM_CH-1:0]             heater_on,
    output logic [NUM_CH*BIT_WIDTH-1:0]   cur_code,
    output logic [NUM_CH-1:0]             settled
);

    localparam int                   DIV_W    = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(UPDATE_DIV - 1);
    localparam logic [BIT_WIDTH-1:0] STEP_C   = BIT_WIDTH'(RAMP_STEP);
    localparam logic [BIT_WIDTH-1:0] INIT_C   = BIT_WIDTH'(INIT_CODE);

    // ------------------------------------------------------------------
    // Config port: a two-state handshake. In READY a request is latched
    // into the holding register; HOLD lasts one cycle, during which the
    // held code is committed to its channel's target.
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } cfg_state_t;

    cfg_state_t             r_state;
    cfg_state_t             w_state_next;
    logic                   w_accept;
    logic                   w_hold_wr;
    logic [CH_W-1:0]        r_hold_ch;
    logic [BIT_WIDTH-1:0]   r_hold_code;

    // Config FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Config FSM next-state: accept in READY, always return from HOLD
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_READY: begin
                if (cfg_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_READY;
            end
        endcase
    end

    assign cfg_ready = (r_state == ST_READY);
    assign w_hold_wr = (r_state == ST_HOLD);

    // Holding register captures channel and code on an accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_ch   <= '0;
            r_hold_code <= '0;
        end else if (w_accept) begin
            r_hold_ch   <= cfg_ch;
            r_hold_code <= cfg_code;
        end
    end

    // ------------------------------------------------------------------
    // Ramp divider: free-running, independent of enable, so the tick
    // phase is fixed relative to reset release.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_ramp;

    // Divider counts 0..UPDATE_DIV-1 and wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_tick = (r_div == DIV_LAST);
    assign w_ramp = w_tick & enable;

    // ------------------------------------------------------------------
    // Per-channel target, ramp, settled flag and sigma-delta modulator.
    // An out-of-range held channel matches no gi, so it is dropped here.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
`ifdef THERMAL_TUNER_STAGGER_EN
            localparam logic [BIT_WIDTH-1:0] ACC_RST =
                BIT_WIDTH'((gi * (2 ** BIT_WIDTH)) / NUM_CH);
`else
            localparam logic [BIT_WIDTH-1:0] ACC_RST = '0;
`endif

            logic                 w_sel;
            logic [BIT_WIDTH-1:0] r_tgt;
            logic [BIT_WIDTH-1:0] r_cur;
            logic [BIT_WIDTH-1:0] r_acc;
            logic                 r_heat;
            logic                 r_settled;
            logic [BIT_WIDTH-1:0] w_tgt_next;
            logic [BIT_WIDTH-1:0] w_cur_next;
            logic [BIT_WIDTH-1:0] w_up_gap;
            logic [BIT_WIDTH-1:0] w_dn_gap;
            logic [BIT_WIDTH:0]   w_sum;

            assign w_sel    = w_hold_wr && (r_hold_ch == CH_W'(gi));
            assign w_up_gap = r_tgt - r_cur;
            assign w_dn_gap = r_cur - r_tgt;

            // Next target/current: the ramp compares against the old target,
            // so a write landing on a tick only takes effect on the next tick
            always_comb begin
                w_tgt_next = r_tgt;
                w_cur_next = r_cur;
                if (w_sel) begin
                    w_tgt_next = r_hold_code;
                end
                if (w_ramp) begin
                    if (r_cur < r_tgt) begin
                        w_cur_next = r_cur + ((w_up_gap > STEP_C) ? STEP_C : w_up_gap);
                    end else if (r_cur > r_tgt) begin
                        w_cur_next = r_cur - ((w_dn_gap > STEP_C) ? STEP_C : w_dn_gap);
                    end
                end
            end

            // Target, current code and settled flag move together
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tgt     <= INIT_C;
                    r_cur     <= INIT_C;
                    r_settled <= 1'b1;
                end else begin
                    r_tgt     <= w_tgt_next;
                    r_cur     <= w_cur_next;
                    r_settled <= (w_cur_next == w_tgt_next);
                end
            end

            assign w_sum = {1'b0, r_acc} + {1'b0, r_cur};

            // First-order modulator: carry out of acc+cur is the heater pulse
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_acc  <= ACC_RST;
                    r_heat <= 1'b0;
                end else if (enable) begin
                    r_acc  <= w_sum[BIT_WIDTH-1:0];
                    r_heat <= w_sum[BIT_WIDTH];
                end else begin
                    r_acc  <= ACC_RST;
                    r_heat <= 1'b0;
                end
            end

            assign cur_code[gi*BIT_WIDTH +: BIT_WIDTH] = r_cur;
            assign heater_on[gi]                       = r_heat;
            assign settled[gi]                         = r_settled;
        end
    endgenerate

endmodule

// File: tb/tb_thermal_tuner_array.sv
// Directed bench for thermal_tuner_array: duty counts, ramp steps, config
// handshake, write/tick collision, enable freeze and asynchronous reset.
// A NUM_CH=3 instance provides an unrepresented-but-encodable channel index.

module tb_thermal_tuner_array;

    logic clk;
    logic rst_n;
    logic enable;

    // Main instance: INIT 0, step 4, divider 16
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [7:0]  cfg_code;
    logic [3:0]  heater_on;
    logic [31:0] cur_code;
    logic [3:0]  settled;

    // Duty instances
    logic        idle_valid;
    logic [1:0]  idle_ch;
    logic [7:0]  idle_code;
    logic        d64_ready;
    logic [3:0]  d64_heat;
    logic [31:0] d64_cur;
    logic [3:0]  d64_settled;
    logic        d255_ready;
    logic [3:0]  d255_heat;
    logic [31:0] d255_cur;
    logic [3:0]  d255_settled;

    // Three-channel instance for the discard case
    logic        odd_valid;
    logic        odd_ready;
    logic [1:0]  odd_ch;
    logic [7:0]  odd_code;
    logic [2:0]  odd_heat;
    logic [23:0] odd_cur;
    logic [2:0]  odd_settled;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    thermal_tuner_array #(.NUM_CH(4), .BIT_WIDTH(8), .INIT_CODE(0), .RAMP_STEP(4), .UPDATE_DIV(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_code(cfg_code),
        .heater_on(heater_on), .cur_code(cur_code), .settled(settled)
    );

    thermal_tuner_array #(.NUM_CH(4), .BIT_WIDTH(8), .INIT_CODE(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(idle_valid), .cfg_ready(d64_ready), .cfg_ch(idle_ch), .cfg_code(idle_code),
        .heater_on(d64_heat), .cur_code(d64_cur), .settled(d64_settled)
    );

    thermal_tuner_array #(.NUM_CH(4), .BIT_WIDTH(8), .INIT_CODE(255)) u_d255 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(idle_valid), .cfg_ready(d255_ready), .cfg_ch(idle_ch), .cfg_code(idle_code),
        .heater_on(d255_heat), .cur_code(d255_cur), .settled(d255_settled)
    );

    thermal_tuner_array #(.NUM_CH(3), .BIT_WIDTH(8), .INIT_CODE(0), .RAMP_STEP(4), .UPDATE_DIV(16)) u_odd (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_valid(odd_valid), .cfg_ready(odd_ready), .cfg_ch(odd_ch), .cfg_code(odd_code),
        .heater_on(odd_heat), .cur_code(odd_cur), .settled(odd_settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d64_hi [4];
        int d255_hi;
        int main_hi;
        int first_hi;

        rst_n      = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = 2'd0;
        cfg_code   = 8'd0;
        idle_valid = 1'b0;
        idle_ch    = 2'd0;
        idle_code  = 8'd0;
        odd_valid  = 1'b0;
        odd_ch     = 2'd0;
        odd_code   = 8'd0;

        // Reset state
        #22;
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_settled", {28'd0, settled}, 32'hF);
        check("rst_heater", {28'd0, heater_on}, 32'h0);
        check("rst_cur", cur_code, 32'h0);
        check("rst_d64_cur", d64_cur, 32'h40404040);

        // Duty window: 256 enabled cycles
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc    = 0;
        for (int c = 0; c < 4; c++) d64_hi[c] = 0;
        d255_hi  = 0;
        main_hi  = 0;
        first_hi = -1;
        for (int k = 0; k < 256; k++) begin
            step();
            for (int c = 0; c < 4; c++) if (d64_heat[c]) d64_hi[c]++;
            if (d64_heat[0] && first_hi < 0) first_hi = cyc;
            if (d255_heat[0]) d255_hi++;
            if (|heater_on) main_hi++;
        end
        for (int c = 0; c < 4; c++) check($sformatf("duty64_ch%0d", c), d64_hi[c], 32'd64);
        check("duty64_first", first_hi, 32'd4);
        check("duty255", d255_hi, 32'd255);
        check("duty0", main_hi, 32'd0);

        // Ramp ch2 -> 10, plus an out-of-range write on the 3-channel build
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_code = 8'd10;
        odd_valid = 1'b1; odd_ch = 2'd3; odd_code = 8'd50;
        step();                                        // 257: accepted
        check("ramp_ready_low", {31'd0, cfg_ready}, 32'd0);
        check("odd_ready_low", {31'd0, odd_ready}, 32'd0);
        cfg_valid = 1'b0;
        odd_valid = 1'b0;
        step();                                        // 258: target lands
        check("ramp_ready_back", {31'd0, cfg_ready}, 32'd1);
        check("ramp_settled_drop", {28'd0, settled}, 32'hB);
        check("odd_discard_settled", {29'd0, odd_settled}, 32'h7);
        step_to(271);
        check("ramp_pre_tick", cur_code, 32'h0);
        step_to(272);
        check("ramp_tick1", cur_code, 32'h00040000);
        check("odd_discard_cur", {8'd0, odd_cur}, 32'h0);
        step_to(288);
        check("ramp_tick2", cur_code, 32'h00080000);
        check("ramp_settled_mid", {28'd0, settled}, 32'hB);
        step_to(304);
        check("ramp_tick3", cur_code, 32'h000A0000);
        check("ramp_settled_done", {28'd0, settled}, 32'hF);

        // Back-to-back writes with cfg_valid held high
        check("hs_ready0", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_code = 8'd12;
        odd_valid = 1'b1; odd_ch = 2'd1; odd_code = 8'd8;
        step();                                        // 305
        check("hs_ready1", {31'd0, cfg_ready}, 32'd0);
        odd_valid = 1'b0;
        cfg_ch = 2'd1; cfg_code = 8'd30;
        step();                                        // 306
        check("hs_ready2", {31'd0, cfg_ready}, 32'd1);
        check("hs_land0", {28'd0, settled}, 32'hE);
        check("odd_land1", {29'd0, odd_settled}, 32'h5);
        step();                                        // 307
        check("hs_ready3", {31'd0, cfg_ready}, 32'd0);
        cfg_ch = 2'd3; cfg_code = 8'd7;
        step();                                        // 308
        check("hs_ready4", {31'd0, cfg_ready}, 32'd1);
        check("hs_land1", {28'd0, settled}, 32'hC);
        step();                                        // 309
        check("hs_ready5", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        step();                                        // 310
        check("hs_ready6", {31'd0, cfg_ready}, 32'd1);
        check("hs_land3", {28'd0, settled}, 32'h4);
        step_to(320);
        check("multi_tick1", cur_code, 32'h040A0404);
        check("odd_tick1", {8'd0, odd_cur}, 32'h000400);
        step_to(336);
        check("multi_tick2", cur_code, 32'h070A0808);
        check("odd_settled", {29'd0, odd_settled}, 32'h7);
        step_to(352);
        check("multi_tick3", cur_code, 32'h070A0C0C);

        // Collision: ch0 write to 20 lands on the tick at 368
        step_to(366);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_code = 8'd20;
        step();                                        // 367: accepted
        cfg_valid = 1'b0;
        step();                                        // 368: tick + target write
        check("coll_hold", cur_code, 32'h070A100C);
        check("coll_settled", {28'd0, settled}, 32'hC);
        step_to(384);
        check("coll_step", cur_code, 32'h070A1410);
        step_to(400);
        check("coll_done", cur_code, 32'h070A1814);
        check("coll_settled_done", {28'd0, settled}, 32'hD);

        // Enable off mid-ramp freezes codes and silences heaters
        step_to(405);
        check("en_d255_on", {28'd0, d255_heat}, 32'hF);
        enable = 1'b0;
        step();                                        // 406
        check("en_off_d255", {28'd0, d255_heat}, 32'h0);
        check("en_off_main", {28'd0, heater_on}, 32'h0);
        step_to(432);
        check("en_frozen", cur_code, 32'h070A1814);
        enable = 1'b1;
        step();                                        // 433: acc restarted at 0
        check("en_acc_reset", {28'd0, d255_heat}, 32'h0);
        step();                                        // 434
        check("en_resume_pdm", {28'd0, d255_heat}, 32'hF);
        step_to(448);
        check("en_resume_ramp", cur_code, 32'h070A1C14);

        // Asynchronous reset during a pending write
        step_to(450);
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_code = 8'd99;
        step();                                        // 451: held
        check("rst_pending", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, cfg_ready}, 32'd1);
        check("arst_settled", {28'd0, settled}, 32'hF);
        check("arst_cur", cur_code, 32'h0);
        check("arst_heater", {28'd0, d255_heat}, 32'h0);
        check("arst_d64_cur", d64_cur, 32'h40404040);
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
        step_to(20);
        check("arst_write_lost_cur", cur_code, 32'h0);
        check("arst_write_lost_settled", {28'd0, settled}, 32'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
